axi4_lite_slave_regfile: RTL

Parametrised AXI4-Lite slave register file, the successor to the fixed 8x32 write-only slave. It adds configurable data width and register count, byte strobes, a full read path, and real VALID/READY handshaking with response backpressure. Out-of-range accesses get SLVERR. It sits on the AXI-Lite interconnect as a generic control/status register block.

---
 rtl/axi4_lite_slave_regfile_if.sv | 40 ++++
 rtl/axi4_lite_slave_regfile.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle for the register-file slave.
// The slave modport is the register block and the master modport is the bus driver.
interface axi4_lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, a read path and SLVERR for
// out-of-range indices. The write and read channels run as independent FSMs.
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi4_lite_slave_regfile_if.slave s_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = ADDR_WIDTH - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    w_state_e              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;

    r_state_e              r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_cmt_addr;
    logic [DATA_WIDTH-1:0] w_cmt_data;
    logic [STRB_WIDTH-1:0] w_cmt_strb;
    logic [IDX_W-1:0]      w_cmt_idx;
    logic                  w_cmt_ok;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_ok;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    assign w_aw_hs = s_axi.awvalid & r_awready;
    assign w_w_hs  = s_axi.wvalid  & r_wready;
    assign w_ar_hs = s_axi.arvalid & r_arready;

    // Readies are zero in W_RESP, so a commit can only come from the three collecting states.
    assign w_commit   = (w_aw_hs & w_w_hs)
                      | ((r_wstate == W_HAVE_A) & w_w_hs)
                      | ((r_wstate == W_HAVE_D) & w_aw_hs);
    assign w_cmt_addr = (r_wstate == W_HAVE_A) ? r_aw_addr : s_axi.awaddr;
    assign w_cmt_data = (r_wstate == W_HAVE_D) ? r_wdata   : s_axi.wdata;
    assign w_cmt_strb = (r_wstate == W_HAVE_D) ? r_wstrb   : s_axi.wstrb;
    assign w_cmt_idx  = w_cmt_addr[ADDR_WIDTH-1:LSB];
    assign w_cmt_ok   = idx_in_range(w_cmt_idx);

    assign w_ar_idx = s_axi.araddr[ADDR_WIDTH-1:LSB];
    assign w_ar_ok  = idx_in_range(w_ar_idx);

    // NOTE: give every always_comb output a default before any branch, otherwise a latch is inferred.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) w_rd_data = r_regs[i];
        end
    end

    // NOTE: the register array is cleared by the async reset because its contents are architectural state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_cmt_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_cmt_idx == IDX_W'(i) && w_cmt_strb[b])
                        r_regs[i][8*b +: 8] <= w_cmt_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_commit) begin
                r_wstate  <= W_RESP;
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_cmt_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (r_wstate)
                    W_IDLE: begin
                        if (w_aw_hs) begin
                            r_aw_addr <= s_axi.awaddr;
                            r_awready <= 1'b0;
                            r_wstate  <= W_HAVE_A;
                        end else if (w_w_hs) begin
                            r_wdata  <= s_axi.wdata;
                            r_wstrb  <= s_axi.wstrb;
                            r_wready <= 1'b0;
                            r_wstate <= W_HAVE_D;
                        end
                    end
                    W_RESP: begin
                        if (s_axi.bready) begin
                            r_bvalid  <= 1'b0;
                            r_awready <= 1'b1;
                            r_wready  <= 1'b1;
                            r_wstate  <= W_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A same-edge write to the read index is invisible here: r_regs still holds the pre-edge value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_ar_ok ? w_rd_data : '0;
                        r_rresp   <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    // Protection bits and sub-word address bits carry no meaning for this block.
    assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                        s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};
endmodule
